// File: rtl/beam_pkg.sv
// Shared types, defaults and LED bucketing for the beam-forming shift search.
// Pure declarations; no latency or backpressure of its own.
package beam_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_WINDOW     = 30;
    localparam int DEF_ACC_WIDTH  = 22;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        SEARCH  = 2'd2,
        DONE    = 2'd3
    } bf_state_t;

    // Splits the 2W candidate shifts evenly over the eight LEDs.
    function automatic logic [7:0] shift_to_led(input int idx, input int window);
        logic [7:0] one;
        one = 8'h01;
        return one << ((idx * 8) / (2 * window));
    endfunction

endpackage

// File: rtl/beam_search_sequencer_sad_accumulator.sv
// Serial SAD term: |a-b| added with saturation, running minimum with lowest-shift tie rule.
// One term per enabled cycle; final_sad/final_idx are the min/idx including the current term.
module sad_accumulator
    import beam_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
    parameter int SHIFT_W    = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  en,
    input  logic                  last,
    input  logic [SHIFT_W-1:0]    shift,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [ACC_WIDTH-1:0]  final_sad,
    output logic [SHIFT_W-1:0]    final_idx
);

    logic [ACC_WIDTH-1:0] acc;
    logic [ACC_WIDTH-1:0] min_sad;
    logic [SHIFT_W-1:0]   min_idx;
    logic [DATA_WIDTH:0]  diff;
    logic [DATA_WIDTH:0]  mag;
    logic [ACC_WIDTH:0]   sum;
    logic [ACC_WIDTH-1:0] total;
    logic                 better;

    always_comb begin
        diff      = {a[DATA_WIDTH-1], a} - {b[DATA_WIDTH-1], b};
        mag       = diff[DATA_WIDTH] ? (~diff + 1'b1) : diff;
        sum       = {1'b0, acc} + {{(ACC_WIDTH-DATA_WIDTH){1'b0}}, mag};
        total     = sum[ACC_WIDTH] ? '1 : sum[ACC_WIDTH-1:0];
        better    = total < min_sad;
        final_sad = better ? total : min_sad;
        final_idx = better ? shift : min_idx;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc     <= '0;
            min_sad <= '1;
            min_idx <= '0;
        end else if (clear) begin
            acc     <= '0;
            min_sad <= '1;
            min_idx <= '0;
        end else if (en) begin
            if (last) begin
                acc     <= '0;
                min_sad <= final_sad;
                min_idx <= final_idx;
            end else begin
                acc <= total;
            end
        end
    end

endmodule

// File: rtl/beam_search_sequencer.sv
// Frame capture + serial SAD search over 2W shifts; result 2W*W cycles after the last sample.
// No backpressure: samples outside CAPTURE and starts outside IDLE are dropped (BF_AUTO_RESTART_EN loops frames).
module beam_search_sequencer
    import beam_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int WINDOW     = DEF_WINDOW,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
    parameter int SHIFT_W    = $clog2(2*WINDOW)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  sample_valid,
    input  logic [DATA_WIDTH-1:0] left_data_in,
    input  logic [DATA_WIDTH-1:0] right_data_in,
    output logic                  busy,
    output logic                  result_valid,
    output logic [SHIFT_W-1:0]    best_shift,
    output logic [ACC_WIDTH-1:0]  best_sad,
    output logic [7:0]            led_pattern
);

    localparam int FRAME = 3 * WINDOW;
    localparam int N_W   = $clog2(FRAME);
    localparam int J_W   = $clog2(WINDOW);

    bf_state_t            state;
    logic [N_W-1:0]       n;
    logic [J_W-1:0]       j;
    logic [SHIFT_W-1:0]   s;
    logic [DATA_WIDTH-1:0] left_buf  [WINDOW];
    logic [DATA_WIDTH-1:0] right_buf [FRAME];

    logic                 capture_en;
    logic                 frame_full;
    logic                 last_term;
    logic                 last_shift;
    logic [N_W-1:0]       left_wr;
    logic [N_W-1:0]       right_rd;
    logic [ACC_WIDTH-1:0] final_sad;
    logic [SHIFT_W-1:0]   final_idx;

    assign capture_en = (state == CAPTURE) && sample_valid;
    assign frame_full = capture_en && (n == N_W'(FRAME-1));
    assign last_term  = (j == J_W'(WINDOW-1));
    assign last_shift = (s == SHIFT_W'(2*WINDOW-1));
    assign left_wr    = n - N_W'(WINDOW);
    assign right_rd   = N_W'(j) + N_W'(s);

    // Buffers are deliberately left out of reset; every frame overwrites them fully.
    always_ff @(posedge clk) begin
        if (capture_en) begin
            right_buf[n] <= right_data_in;
            if (n >= N_W'(WINDOW) && n < N_W'(2*WINDOW))
                left_buf[left_wr[J_W-1:0]] <= left_data_in;
        end
    end

    sad_accumulator #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH),
        .SHIFT_W    (SHIFT_W)
    ) u_sad (
        .clk       (clk),
        .reset     (reset),
        .clear     (frame_full),
        .en        (state == SEARCH),
        .last      (last_term),
        .shift     (s),
        .a         (left_buf[j]),
        .b         (right_buf[right_rd]),
        .final_sad (final_sad),
        .final_idx (final_idx)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            n            <= '0;
            j            <= '0;
            s            <= '0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            best_shift   <= '0;
            best_sad     <= '0;
            led_pattern  <= 8'h00;
        end else begin
            result_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= CAPTURE;
                        n     <= '0;
                        busy  <= 1'b1;
                    end
                end
                CAPTURE: begin
                    if (sample_valid) begin
                        n <= n + 1'b1;
                        if (frame_full) begin
                            state <= SEARCH;
                            n     <= '0;
                            j     <= '0;
                            s     <= '0;
                        end
                    end
                end
                SEARCH: begin
                    if (last_term) begin
                        j <= '0;
                        if (last_shift) begin
                            // Publish on entry so result_valid is visible during DONE.
                            state        <= DONE;
                            s            <= '0;
                            best_shift   <= final_idx;
                            best_sad     <= final_sad;
                            led_pattern  <= shift_to_led(32'(final_idx), WINDOW);
                            result_valid <= 1'b1;
                        end else begin
                            s <= s + 1'b1;
                        end
                    end else begin
                        j <= j + 1'b1;
                    end
                end
                DONE: begin
`ifdef BF_AUTO_RESTART_EN
                    state <= CAPTURE;
                    n     <= '0;
`else
                    state <= IDLE;
                    busy  <= 1'b0;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_beam_search_sequencer.sv
// Table-driven passes through the beam search sequencer with a scoreboard of expected results.
module tb_beam_search_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic        sample_valid;
    logic [15:0] left_data_in;
    logic [15:0] right_data_in;
    logic        busy, result_valid;
    logic [5:0]  best_shift;
    logic [21:0] best_sad;
    logic [7:0]  led_pattern;
    logic        busy18, result_valid18;
    logic [5:0]  best_shift18;
    logic [17:0] best_sad18;
    logic [7:0]  led_pattern18;

    beam_search_sequencer dut (
        .clk (clk), .reset (reset), .start (start), .sample_valid (sample_valid),
        .left_data_in (left_data_in), .right_data_in (right_data_in),
        .busy (busy), .result_valid (result_valid), .best_shift (best_shift),
        .best_sad (best_sad), .led_pattern (led_pattern)
    );

    beam_search_sequencer #(.ACC_WIDTH(18)) dut18 (
        .clk (clk), .reset (reset), .start (start), .sample_valid (sample_valid),
        .left_data_in (left_data_in), .right_data_in (right_data_in),
        .busy (busy18), .result_valid (result_valid18), .best_shift (best_shift18),
        .best_sad (best_sad18), .led_pattern (led_pattern18)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          pat;
        bit          gaps;
        bit          extra;
        logic [5:0]  shift;
        logic [21:0] sad;
        logic [7:0]  led;
        logic [5:0]  shift18;
        logic [17:0] sad18;
    } vec_t;

    vec_t        vecs [5];
    vec_t        sb [$];
    logic [15:0] rnd [100];
    int          total = 0;
    int          bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void gen(input int pat, input int t, output logic [15:0] l, output logic [15:0] r);
        case (pat)
            0:       begin l = 16'(t * 100 - 4000); r = l; end
            1:       begin l = rnd[t + 10]; r = rnd[t]; end
            3:       begin l = 16'h7fff; r = 16'h8000; end
            default: begin l = 16'h0000; r = 16'h0000; end
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic capture_frame(input int pat, input bit gaps);
        logic [15:0] l, r;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_rise", 32'(busy), 32'd1);
        for (int t = 0; t < 90; t++) begin
            if (gaps) begin
                sample_valid  = 1'b0;
                left_data_in  = 16'($urandom);
                right_data_in = 16'($urandom);
                tick();
            end
            gen(pat, t, l, r);
            sample_valid  = 1'b1;
            left_data_in  = l;
            right_data_in = r;
            tick();
        end
        sample_valid = 1'b0;
    endtask

    task automatic run_pass(input vec_t v);
        vec_t e;
        int   cnt;
        sb.push_back(v);
        capture_frame(v.pat, v.gaps);
        cnt = 0;
        while (!result_valid && cnt < 4000) begin
            if (v.extra) begin
                start         = (cnt % 200) == 5;
                sample_valid  = cnt[0];
                left_data_in  = 16'($urandom);
                right_data_in = 16'($urandom);
            end
            tick();
            cnt++;
        end
        start        = 1'b0;
        sample_valid = 1'b0;
        if (cnt >= 4000) begin
            bad++;
            total++;
            $display("FAIL result_timeout: got no result_valid after %0d cycles, required 1800", cnt);
            return;
        end
        e = sb.pop_front();
        chk("latency",       32'(cnt),            32'd1800);
        chk("best_shift",    32'(best_shift),     32'(e.shift));
        chk("best_sad",      32'(best_sad),       32'(e.sad));
        chk("led_pattern",   32'(led_pattern),    32'(e.led));
        chk("valid18",       32'(result_valid18), 32'd1);
        chk("best_shift18",  32'(best_shift18),   32'(e.shift18));
        chk("best_sad18",    32'(best_sad18),     32'(e.sad18));
        tick();
        chk("valid_pulse",   32'(result_valid),   32'd0);
        chk("busy_fall",     32'(busy),           32'd0);
        chk("shift_held",    32'(best_shift),     32'(e.shift));
    endtask

    initial begin
        vecs[0] = '{pat: 0, gaps: 0, extra: 0, shift: 6'd30, sad: 22'd0,       led: 8'h10, shift18: 6'd30, sad18: 18'd0};
        vecs[1] = '{pat: 1, gaps: 0, extra: 0, shift: 6'd40, sad: 22'd0,       led: 8'h20, shift18: 6'd40, sad18: 18'd0};
        vecs[2] = '{pat: 2, gaps: 0, extra: 0, shift: 6'd0,  sad: 22'd0,       led: 8'h01, shift18: 6'd0,  sad18: 18'd0};
        vecs[3] = '{pat: 3, gaps: 0, extra: 0, shift: 6'd0,  sad: 22'd1966050, led: 8'h01, shift18: 6'd0,  sad18: 18'd262143};
        vecs[4] = '{pat: 0, gaps: 1, extra: 1, shift: 6'd30, sad: 22'd0,       led: 8'h10, shift18: 6'd30, sad18: 18'd0};
        for (int i = 0; i < 100; i++) rnd[i] = 16'($urandom);

        reset         = 1'b1;
        start         = 1'b0;
        sample_valid  = 1'b0;
        left_data_in  = '0;
        right_data_in = '0;
        tick();
        tick();
        chk("rst_busy",  32'(busy),         32'd0);
        chk("rst_valid", 32'(result_valid), 32'd0);
        chk("rst_shift", 32'(best_shift),   32'd0);
        chk("rst_sad",   32'(best_sad),     32'd0);
        chk("rst_led",   32'(led_pattern),  32'd0);
        reset = 1'b0;
        tick();

        // Samples and starts before any start must not launch a pass.
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        chk("idle_busy", 32'(busy), 32'd0);

        for (int i = 0; i < 5; i++) run_pass(vecs[i]);

        // Reset in the middle of SEARCH, then a fresh pass must be correct.
        capture_frame(1, 1'b0);
        repeat (300) tick();
        chk("mid_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        sb.delete();
        tick();
        chk("midrst_busy",  32'(busy),         32'd0);
        chk("midrst_valid", 32'(result_valid), 32'd0);
        chk("midrst_shift", 32'(best_shift),   32'd0);
        chk("midrst_sad",   32'(best_sad),     32'd0);
        chk("midrst_led",   32'(led_pattern),  32'd0);
        reset = 1'b0;
        repeat (2000) begin
            tick();
            if (result_valid) break;
        end
        chk("no_stale_result", 32'(result_valid), 32'd0);
        run_pass(vecs[1]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/beam_search_sequencer.md
# beam_search_sequencer

Multi-cycle controller for the two-microphone beam-forming path. It captures a frame of left/right samples and runs a serial sum-of-absolute-differences (SAD) search over all candidate shifts, one sample difference per clock. It then publishes the best-matching shift and the one-hot LED direction pattern. It sits between the audio sample source and the LED driver, replacing the single-cycle all-shift search with a resource-shared, sequenced search.

## Interface
- DATA_WIDTH, 16, sample width, signed two's complement
- WINDOW, 30, correlation window W in samples; frame = 3W right samples, W left samples
- ACC_WIDTH, 22, SAD accumulator and min register width
- SHIFT_W, $clog2(2*WINDOW), width of shift index
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- start  in  1  request one capture+search pass; sampled only in IDLE
- sample_valid  in  1  left_data_in/right_data_in valid this cycle
- left_data_in  in  DATA_WIDTH  left microphone sample
- right_data_in  in  DATA_WIDTH  right microphone sample
- busy  out  1  high in CAPTURE, SEARCH, DONE
- result_valid  out  1  one-cycle pulse when a new result is published
- best_shift  out  SHIFT_W  winning shift, held until next publish
- best_sad  out  ACC_WIDTH  SAD of winning shift, held
- led_pattern  out  8  one-hot direction, held

## Operation
- States: IDLE, CAPTURE, SEARCH, DONE.
- IDLE: on start=1 -> CAPTURE, clear capture count n.
- CAPTURE: each cycle with sample_valid=1 stores right[n]=right_data_in. For W<=n<2W it also stores left[n-W]=left_data_in. Then n++. After the sample with n=3W-1 -> SEARCH with s=0, j=0, acc=0, min=all ones, idx=0.
- SEARCH: one term per cycle, acc += |left[j] - right[j+s]|.
  - Difference is computed at DATA_WIDTH+1 signed; its magnitude is zero-extended.
  - Accumulation saturates at 2^ACC_WIDTH-1.
  - At j=W-1, the completed sum (including the current term) is compared with min. A strictly smaller sum updates min and idx=s, so ties keep the lowest shift. Then acc=0, j=0, s++.
  - After s=2W-1 completes -> DONE.
- DONE: best_shift=idx, best_sad=min, led_pattern=1<<((idx*8)/(2W)), result_valid=1 for this cycle -> IDLE.
- start outside IDLE: ignored. sample_valid outside CAPTURE: ignored. Gaps in sample_valid during CAPTURE stall capture only.
- Reset at any time: state IDLE, counters 0, accumulator 0, buffers not cleared.

## Timing
- Reset values: busy=0, result_valid=0, best_shift=0, best_sad=0, led_pattern=8'h00.
- busy rises the cycle after start is accepted and falls the cycle after DONE.
- SEARCH lasts exactly 2W*W cycles (1800 at defaults).
- The cycle after the 3W-th accepted sample is search cycle 0. result_valid asserts 2W*W cycles after entering SEARCH.
- Outputs change only in DONE and are registered; no combinational path from inputs to outputs.

## Configuration
- BF_AUTO_RESTART_EN defined: DONE goes directly to CAPTURE with n=0, so frames run back-to-back without start. busy stays high after the first start until reset.
- BF_AUTO_RESTART_EN undefined: DONE -> IDLE; each pass needs a start pulse.

## Structure
- Package beam_pkg holds:
  - state enum bf_state_t
  - DATA_WIDTH/WINDOW/ACC_WIDTH defaults
  - function shift_to_led(idx) returning the one-hot LED bucket
- One sub-module, sad_accumulator: abs-difference, saturating accumulate, clear, compare-and-hold-min. The top owns the FSM, counters and sample buffers.

## Test plan
- Identical left/right ramp, start pulse, 90 samples -> best_shift=30, best_sad=0, led_pattern=8'h10, result_valid exactly 1800 cycles after search start.
- right(t)=left(t-10), random signed data -> best_shift=40, best_sad=0, led_pattern=8'h20.
- All-zero inputs -> every SAD ties at 0; best_shift=0, led_pattern=8'h01 (lowest-shift tie rule).
- left constant +32767, right constant -32768 -> best_sad=30*65535=1966050, no saturation; rerun with ACC_WIDTH=18 -> best_sad=262143.
- sample_valid toggled every other cycle plus start pulses during SEARCH -> capture uses only valid samples; extra starts ignored; result identical to the gap-free run.
- reset asserted mid-SEARCH -> next cycle busy=0, outputs at reset values; a new start runs a full correct pass.
